dmem_responder: RTL and testbench

- Behavioural data-memory target: the responder end of the core's dmem request/busy/rdy protocol.
- Accepts one read or write request at a time and commits writes with byte granularity into a little-endian byte array.
- Returns read data after a parameterised latency.
- Sits beside the core in simulation benches; it is the model the core's load/store path talks to.

---
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Behavioural data-memory target for the core's dmem request/busy/rdy
//   protocol. It accepts one read or write at a time, commits writes byte by
//   byte into a little-endian byte array and answers after LATENCY cycles.
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous reset, active-high (memory contents are kept)
//   dmem_rd_en_i    read request
//   dmem_wr_en_i    write request (wins over a simultaneous read)
//   dmem_addr_i     byte address, only addr mod MEM_BYTES is used
//   dmem_wr_size_i  store size code: 0=1B 1=2B 2=4B 3=8B, 4-7 write nothing
//   dmem_wr_data_i  store data, low bytes used
//   dmem_busy_o     request in flight, new requests are ignored
//   dmem_rdy_o      one-cycle completion pulse
//   dmem_rd_data_o  raw read bytes, held until the next read completes
//   dmem_err_o      access error flag, pulses with dmem_rdy_o
//
// Build option
//   DMEM_RESPONDER_CHECK_EN  when defined, flags (and reports via $error)
//   out-of-range addresses, wrapping accesses, bad size codes and
//   simultaneous read+write. When undefined dmem_err_o is tied low.
module dmem_responder #(
   parameter int DATA_WIDTH  = 64,
   parameter int FETCH_WIDTH = 64,
   parameter int MEM_BYTES   = 65536,
   parameter int LATENCY     = 2,
   parameter     INIT_FILE   = ""
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              dmem_rd_en_i,
   input  logic                              dmem_wr_en_i,
   input  logic [DATA_WIDTH-1:0]             dmem_addr_i,
   input  logic [$clog2(FETCH_WIDTH/8)-1:0]  dmem_wr_size_i,
   input  logic [FETCH_WIDTH-1:0]            dmem_wr_data_i,
   output logic                              dmem_busy_o,
   output logic                              dmem_rdy_o,
   output logic [FETCH_WIDTH-1:0]            dmem_rd_data_o,
   output logic                              dmem_err_o
);

   localparam int FB = FETCH_WIDTH / 8;
   localparam int AW = $clog2(MEM_BYTES);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   logic [7:0]             mem [MEM_BYTES];
   state_t                 state;
   logic [CW-1:0]          cnt;
   logic                   op_rd;
   logic [FETCH_WIDTH-1:0] rd_buf;
   logic [AW-1:0]          addr_idx;
   logic                   accept;
   logic                   is_read;
   logic [31:0]            wr_nbytes;
   logic [FETCH_WIDTH-1:0] rd_sample;

   assign addr_idx = dmem_addr_i[AW-1:0];
   assign accept   = (state == IDLE) && (dmem_rd_en_i || dmem_wr_en_i);
   assign is_read  = dmem_rd_en_i && !dmem_wr_en_i;

   // Byte count of a store; size codes above 3 write nothing.
   always_comb begin
      wr_nbytes = '0;
      if (32'(dmem_wr_size_i) <= 32'd3) begin
         wr_nbytes = 32'd1 << dmem_wr_size_i;
         if (wr_nbytes > 32'(FB)) wr_nbytes = 32'(FB);
      end
   end

   // Index arithmetic is AW bits wide, so multi-byte accesses wrap naturally.
   always_comb begin
      rd_sample = '0;
      for (int unsigned k = 0; k < FB; k++)
         rd_sample[8*k +: 8] = mem[addr_idx + AW'(k)];
   end

   always_ff @(posedge clk) begin
      if (!rst && accept && dmem_wr_en_i) begin
         for (int unsigned k = 0; k < FB; k++)
            if (k < wr_nbytes) mem[addr_idx + AW'(k)] <= dmem_wr_data_i[8*k +: 8];
      end
   end

`ifdef DMEM_RESPONDER_CHECK_EN
   logic        req_err;
   logic        err_pend;
   logic [31:0] acc_bytes;

   always_comb begin
      acc_bytes = dmem_wr_en_i ? wr_nbytes : 32'(FB);
      req_err   = ((dmem_addr_i >> AW) != '0)
               || ((32'(addr_idx) + acc_bytes) > 32'(MEM_BYTES))
               || (dmem_wr_en_i && (32'(dmem_wr_size_i) > 32'd3))
               || (dmem_rd_en_i && dmem_wr_en_i);
   end

   always_ff @(posedge clk) begin
      if (!rst && accept && req_err)
         $error("dmem_responder: bad access addr=%h rd=%b wr=%b size=%0d",
                dmem_addr_i, dmem_rd_en_i, dmem_wr_en_i, dmem_wr_size_i);
   end
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^dmem_addr_i;
   assign dmem_err_o     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         op_rd          <= 1'b0;
         rd_buf         <= '0;
         dmem_busy_o    <= 1'b0;
         dmem_rdy_o     <= 1'b0;
         dmem_rd_data_o <= '0;
`ifdef DMEM_RESPONDER_CHECK_EN
         err_pend       <= 1'b0;
         dmem_err_o     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               dmem_rdy_o <= 1'b0;
`ifdef DMEM_RESPONDER_CHECK_EN
               dmem_err_o <= 1'b0;
`endif
               if (accept) begin
                  op_rd       <= is_read;
                  rd_buf      <= rd_sample;
                  dmem_busy_o <= 1'b1;
`ifdef DMEM_RESPONDER_CHECK_EN
                  err_pend    <= req_err;
`endif
                  // With a single cycle of latency WAIT is skipped entirely.
                  if (LATENCY == 1) begin
                     state      <= DONE;
                     dmem_rdy_o <= 1'b1;
                     if (is_read) dmem_rd_data_o <= rd_sample;
`ifdef DMEM_RESPONDER_CHECK_EN
                     dmem_err_o <= req_err;
`endif
                  end else begin
                     state <= WAIT;
                     cnt   <= CW'(LATENCY - 1);
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state      <= DONE;
                  dmem_rdy_o <= 1'b1;
                  if (op_rd) dmem_rd_data_o <= rd_buf;
`ifdef DMEM_RESPONDER_CHECK_EN
                  dmem_err_o <= err_pend;
`endif
               end
            end
            DONE: begin
               state       <= IDLE;
               dmem_rdy_o  <= 1'b0;
               dmem_busy_o <= 1'b0;
`ifdef DMEM_RESPONDER_CHECK_EN
               dmem_err_o  <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: a LATENCY=2 instance exercised through a
// byte-array reference model with an expected-response queue, plus a
// LATENCY=1 instance for back-to-back timing.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        a_rd, a_wr, a_busy, a_rdy, a_err;
   logic [63:0] a_addr, a_wdata, a_rdata;
   logic [2:0]  a_size;
   logic        b_rd, b_wr, b_busy, b_rdy, b_err;
   logic [63:0] b_addr, b_wdata, b_rdata;
   logic [2:0]  b_size;

   dmem_responder #(.DATA_WIDTH(64), .FETCH_WIDTH(64), .MEM_BYTES(65536), .LATENCY(2)) u_dut (
      .clk(clk), .rst(rst), .dmem_rd_en_i(a_rd), .dmem_wr_en_i(a_wr),
      .dmem_addr_i(a_addr), .dmem_wr_size_i(a_size), .dmem_wr_data_i(a_wdata),
      .dmem_busy_o(a_busy), .dmem_rdy_o(a_rdy), .dmem_rd_data_o(a_rdata), .dmem_err_o(a_err));

   dmem_responder #(.DATA_WIDTH(64), .FETCH_WIDTH(64), .MEM_BYTES(65536), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .dmem_rd_en_i(b_rd), .dmem_wr_en_i(b_wr),
      .dmem_addr_i(b_addr), .dmem_wr_size_i(b_size), .dmem_wr_data_i(b_wdata),
      .dmem_busy_o(b_busy), .dmem_rdy_o(b_rdy), .dmem_rd_data_o(b_rdata), .dmem_err_o(b_err));

   typedef struct packed {logic [63:0] rd; logic err;} exp_t;
   typedef struct packed {
      logic rd; logic wr; logic [63:0] addr; logic [2:0] size; logic [63:0] data;
      logic chk; logic [63:0] want;
   } op_t;

   exp_t        exp_q[$];
   logic [7:0]  mm [65536];
   logic [63:0] last_rd;
   int          vectors, miscompares;

   // Drive one request in the current cycle, update the model, queue the
   // expected completion, and return one cycle after acceptance.
   task automatic issue(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [2:0] size, input logic [63:0] data);
      exp_t        e;
      logic [15:0] idx;
      logic [63:0] r;
      int          nb;
      idx = addr[15:0];
      nb  = (size <= 3'd3) ? (1 << size) : 0;
      if (wr) begin
         for (int k = 0; k < nb; k++) mm[idx + 16'(k)] = data[8*k +: 8];
         e.rd = last_rd;
      end else begin
         for (int k = 0; k < 8; k++) r[8*k +: 8] = mm[idx + 16'(k)];
         e.rd    = r;
         last_rd = r;
      end
`ifdef DMEM_RESPONDER_CHECK_EN
      e.err = (addr[63:16] != 48'd0) || ((int'(idx) + (wr ? nb : 8)) > 65536)
           || (wr && size > 3'd3) || (rd && wr);
`else
      e.err = 1'b0;
`endif
      exp_q.push_back(e);
      a_rd = rd; a_wr = wr; a_addr = addr; a_size = size; a_wdata = data;
      @(posedge clk); #1;
      a_rd = 1'b0; a_wr = 1'b0;
   endtask

   // Bounded wait for rdy; reports cycles since acceptance, whether busy was
   // high throughout, and busy in the cycle after the pulse.
   task automatic await_rdy(output int n, output logic bsy, output logic bsy_after,
                            output logic e, output logic [63:0] d);
      n = 1; bsy = 1'b1;
      while (!a_rdy && n < 16) begin
         bsy &= a_busy;
         @(posedge clk); #1;
         n++;
      end
      bsy &= a_busy;
      e = a_err;
      d = a_rdata;
      @(posedge clk); #1;
      bsy_after = a_busy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_rd = 0; a_wr = 0; a_addr = '0; a_size = '0; a_wdata = '0;
      b_rd = 0; b_wr = 0; b_addr = '0; b_size = '0; b_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", a_busy); end
      vectors++; if (a_rdy !== 1'b0) begin miscompares++; $display("FAIL reset rdy: got %b want 0", a_rdy); end
      vectors++; if (a_rdata !== 64'd0) begin miscompares++; $display("FAIL reset rd_data: got %h want 0", a_rdata); end
      vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL reset err: got %b want 0", a_err); end
      vectors++; if (b_busy !== 1'b0) begin miscompares++; $display("FAIL reset lat1 busy: got %b want 0", b_busy); end
      rst = 1'b0;
      last_rd = '0;
   endtask

   task automatic test_directed();
      op_t tbl [17] = '{
         '{1'b0, 1'b1, 64'h100,         3'd3, 64'h1122334455667788, 1'b0, 64'h0},
         '{1'b1, 1'b0, 64'h100,         3'd0, 64'h0, 1'b1, 64'h1122334455667788},
         '{1'b0, 1'b1, 64'h300,         3'd3, 64'h0, 1'b0, 64'h0},
         '{1'b0, 1'b1, 64'h303,         3'd0, 64'hFF, 1'b0, 64'h0},
         '{1'b1, 1'b0, 64'h300,         3'd0, 64'h0, 1'b1, 64'h00000000FF000000},
         '{1'b0, 1'b1, 64'h304,         3'd1, 64'hABCD, 1'b0, 64'h0},
         '{1'b1, 1'b0, 64'h300,         3'd0, 64'h0, 1'b1, 64'h0000ABCDFF000000},
         '{1'b0, 1'b1, 64'hFFF8,        3'd3, 64'h0, 1'b0, 64'h0},
         '{1'b0, 1'b1, 64'h0,           3'd3, 64'h0, 1'b0, 64'h0},
         '{1'b0, 1'b1, 64'hFFFE,        3'd2, 64'hDEADBEEF, 1'b0, 64'h0},
         '{1'b1, 1'b0, 64'hFFFE,        3'd0, 64'h0, 1'b1, 64'h00000000DEADBEEF},
         '{1'b1, 1'b0, 64'hFFFC,        3'd0, 64'h0, 1'b1, 64'h0000DEADBEEF0000},
         '{1'b0, 1'b1, 64'h100,         3'd5, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0},
         '{1'b1, 1'b0, 64'h100,         3'd0, 64'h0, 1'b1, 64'h1122334455667788},
         '{1'b1, 1'b1, 64'h400,         3'd3, 64'hCAFEF00D12345678, 1'b0, 64'h0},
         '{1'b1, 1'b0, 64'h400,         3'd0, 64'h0, 1'b1, 64'hCAFEF00D12345678},
         '{1'b1, 1'b0, 64'h1_0000_0100, 3'd0, 64'h0, 1'b1, 64'h1122334455667788}
      };
      int n; logic b, ba, e; logic [63:0] d; exp_t x;
      for (int i = 0; i < 17; i++) begin
         issue(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].data);
         await_rdy(n, b, ba, e, d);
         x = exp_q.pop_front();
         vectors++; if (n !== 2) begin miscompares++; $display("FAIL directed[%0d] latency: got %0d want 2", i, n); end
         vectors++; if (b !== 1'b1) begin miscompares++; $display("FAIL directed[%0d] busy_during: got %b want 1", i, b); end
         vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL directed[%0d] busy_after: got %b want 0", i, ba); end
         vectors++; if (d !== x.rd) begin miscompares++; $display("FAIL directed[%0d] rd_data: got %h want %h", i, d, x.rd); end
         vectors++; if (e !== x.err) begin miscompares++; $display("FAIL directed[%0d] err: got %b want %b", i, e, x.err); end
         if (tbl[i].chk) begin
            vectors++; if (d !== tbl[i].want) begin miscompares++; $display("FAIL directed[%0d] rd_const: got %h want %h", i, d, tbl[i].want); end
         end
      end
   endtask

   task automatic test_busy_drop();
      int pulses; logic [63:0] d; exp_t x;
      pulses = 0; d = '0;
      issue(1'b1, 1'b0, 64'h100, 3'd0, 64'h0);
      a_rd = 1'b1; a_addr = 64'h200;
      for (int c = 1; c <= 5; c++) begin
         if (a_rdy) begin pulses++; d = a_rdata; end
         @(posedge clk); #1;
         if (c == 2) a_rd = 1'b0;
      end
      x = exp_q.pop_front();
      vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL busy_drop pulses: got %0d want 1", pulses); end
      vectors++; if (d !== x.rd) begin miscompares++; $display("FAIL busy_drop rd_data: got %h want %h", d, x.rd); end
      vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL busy_drop idle_busy: got %b want 0", a_busy); end
   endtask

   task automatic test_reset_mid();
      int pulses, n; logic b, ba, e; logic [63:0] d; exp_t x;
      pulses = 0;
      a_rd = 1'b1; a_addr = 64'h300;
      @(posedge clk); #1;
      a_rd = 1'b0;
      rst  = 1'b1;
      @(posedge clk); #1;
      vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_mid busy: got %b want 0", a_busy); end
      vectors++; if (a_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_mid rdy: got %b want 0", a_rdy); end
      vectors++; if (a_rdata !== 64'd0) begin miscompares++; $display("FAIL reset_mid rd_data: got %h want 0", a_rdata); end
      rst = 1'b0;
      last_rd = '0;
      for (int c = 0; c < 4; c++) begin
         if (a_rdy) pulses++;
         @(posedge clk); #1;
      end
      vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL reset_mid stray_rdy: got %0d want 0", pulses); end
      issue(1'b1, 1'b0, 64'h300, 3'd0, 64'h0);
      await_rdy(n, b, ba, e, d);
      x = exp_q.pop_front();
      vectors++; if (n !== 2) begin miscompares++; $display("FAIL reset_mid post_latency: got %0d want 2", n); end
      vectors++; if (d !== x.rd) begin miscompares++; $display("FAIL reset_mid post_rd_data: got %h want %h", d, x.rd); end
   endtask

   task automatic test_random();
      int n; logic b, ba, e; logic [63:0] d; exp_t x;
      logic rd; logic [2:0] sz; logic [63:0] ad;
      for (int i = 0; i < 38; i++) begin
         if (i < 8) begin
            rd = 1'b0; sz = 3'd3; ad = 64'h500 + 64'(8*i);
         end else begin
            rd = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 4));
            ad = 64'h500 + 64'($urandom_range(0, 'h37));
         end
         issue(rd, !rd, ad, sz, {$urandom, $urandom});
         await_rdy(n, b, ba, e, d);
         x = exp_q.pop_front();
         vectors++; if (n !== 2) begin miscompares++; $display("FAIL random[%0d] latency: got %0d want 2", i, n); end
         vectors++; if (d !== x.rd) begin miscompares++; $display("FAIL random[%0d] rd_data: got %h want %h", i, d, x.rd); end
         vectors++; if (b !== 1'b1 || ba !== 1'b0) begin miscompares++; $display("FAIL random[%0d] busy: got %b/%b want 1/0", i, b, ba); end
      end
   endtask

   task automatic test_back_to_back_lat1();
      b_wr = 1'b1; b_size = 3'd3; b_addr = 64'h10; b_wdata = 64'h0123456789ABCDEF;
      @(posedge clk); #1;
      b_wr = 1'b0;
      @(posedge clk); #1;
      b_wr = 1'b1; b_addr = 64'h18; b_wdata = 64'hFEDCBA9876543210;
      @(posedge clk); #1;
      b_wr = 1'b0;
      @(posedge clk); #1;
      // cycle 0: first read; rd_en stays high through the busy cycle
      b_rd = 1'b1; b_addr = 64'h10;
      @(posedge clk); #1;
      vectors++; if (b_rdy !== 1'b1 || b_busy !== 1'b1) begin miscompares++; $display("FAIL lat1 c1 rdy/busy: got %b/%b want 1/1", b_rdy, b_busy); end
      vectors++; if (b_rdata !== 64'h0123456789ABCDEF) begin miscompares++; $display("FAIL lat1 c1 rd_data: got %h want 0123456789abcdef", b_rdata); end
      b_addr = 64'h11;
      @(posedge clk); #1;
      vectors++; if (b_rdy !== 1'b0 || b_busy !== 1'b0) begin miscompares++; $display("FAIL lat1 c2 rdy/busy: got %b/%b want 0/0", b_rdy, b_busy); end
      @(posedge clk); #1;
      b_rd = 1'b0;
      vectors++; if (b_rdy !== 1'b1 || b_busy !== 1'b1) begin miscompares++; $display("FAIL lat1 c3 rdy/busy: got %b/%b want 1/1", b_rdy, b_busy); end
      vectors++; if (b_rdata !== 64'h100123456789ABCD) begin miscompares++; $display("FAIL lat1 c3 rd_data: got %h want 100123456789abcd", b_rdata); end
      @(posedge clk); #1;
      vectors++; if (b_rdy !== 1'b0 || b_busy !== 1'b0) begin miscompares++; $display("FAIL lat1 c4 rdy/busy: got %b/%b want 0/0", b_rdy, b_busy); end
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      test_reset();
      test_directed();
      test_busy_drop();
      test_reset_mid();
      test_random();
      test_back_to_back_lat1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
